// File: rtl/alu_exec_pkg.sv
// Shared ALUOperation codes, FSM state encoding and memory-map base for the execute-stage ALU.
package alu_exec_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_AND    = 4'b0001;
   localparam logic [3:0] OP_OR     = 4'b0010;
   localparam logic [3:0] OP_NOR    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRL    = 4'b0101;
   localparam logic [3:0] OP_LUI    = 4'b0110;
   localparam logic [3:0] OP_SUB    = 4'b0111;
   localparam logic [3:0] OP_JMP    = 4'b1001;
   localparam logic [3:0] OP_MEMMAP = 4'b1010;

   localparam logic [31:0] MEM_BASE_DEFAULT = 32'h1001_0000;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle logical shifter; done pulses on the cycle the final bit shift happens,
// with result carrying that final shifted value.
module alu_serial_shifter #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   start,
   input  logic                   shift_right,
   input  logic [SHAMT_WIDTH-1:0] amount,
   input  logic [DATA_WIDTH-1:0]  data,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  result
);

   logic                   busy;
   logic                   dir_right;
   logic [SHAMT_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0]  work;
   logic [DATA_WIDTH-1:0]  work_shifted;

   assign work_shifted = dir_right ? (work >> 1) : (work << 1);
   assign done         = busy && (cnt == SHAMT_WIDTH'(1));
   assign result       = work_shifted;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy      <= 1'b0;
         dir_right <= 1'b0;
         cnt       <= '0;
         work      <= '0;
      end else if (flush) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         dir_right <= shift_right;
         cnt       <= amount;
         work      <= data;
      end else if (busy) begin
         work <= work_shifted;
         cnt  <= cnt - SHAMT_WIDTH'(1);
         if (cnt == SHAMT_WIDTH'(1)) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: valid/ready input, registered ALUResult/Zero/Illegal toward EX/MEM.
// Define BARREL_SHIFT_EN for single-cycle SLL/SRL; otherwise shifts run serially and stall.
//
// state    | meaning
// ST_IDLE  | ready for a new op (subject to output back-pressure and flush)
// ST_SHIFT | serial shift in flight, in_ready held low
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] MEM_BASE    = DATA_WIDTH'(MEM_BASE_DEFAULT),
   parameter int                    SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             ALUOperation,
   input  logic [DATA_WIDTH-1:0]  A,
   input  logic [DATA_WIDTH-1:0]  B,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  ALUResult,
   output logic                   Zero,
   output logic                   Illegal
);

   logic                  accept;
   logic                  load_result;
   logic                  ov_nxt;
   logic                  ill_nxt;
   logic                  op_illegal;
   logic [DATA_WIDTH-1:0] op_result;
   logic [DATA_WIDTH-1:0] res_nxt;
   logic [DATA_WIDTH-1:0] mm_offset;

   assign accept    = in_valid && in_ready;
   assign mm_offset = A + B - MEM_BASE;

   always_comb begin
      op_result  = '0;
      op_illegal = 1'b0;
      case (ALUOperation)
         OP_ADD:    op_result = A + B;
         OP_AND:    op_result = A & B;
         OP_OR:     op_result = A | B;
         OP_NOR:    op_result = ~(A | B);
`ifdef BARREL_SHIFT_EN
         OP_SLL:    op_result = B << shamt;
         OP_SRL:    op_result = B >> shamt;
`else
         // Only reached with shamt==0; nonzero amounts go through the serial shifter.
         OP_SLL,
         OP_SRL:    op_result = B;
`endif
         OP_LUI:    op_result = B << 16;
         OP_SUB:    op_result = A - B;
         OP_JMP:    op_result = A;
         OP_MEMMAP: op_result = mm_offset >> 2;
         default:   op_illegal = 1'b1;
      endcase
   end

`ifndef BARREL_SHIFT_EN
   alu_state_e            state;
   alu_state_e            state_nxt;
   logic                  is_shift;
   logic                  shift_start;
   logic                  sh_done;
   logic [DATA_WIDTH-1:0] sh_result;

   assign is_shift = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
   assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   alu_serial_shifter #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .start       (shift_start),
      .shift_right (ALUOperation == OP_SRL),
      .amount      (shamt),
      .data        (B),
      .done        (sh_done),
      .result      (sh_result)
   );
`else
   assign in_ready = (!out_valid || out_ready) && !flush;
`endif

   always_comb begin
      ov_nxt      = out_valid && !out_ready;
      load_result = 1'b0;
      res_nxt     = op_result;
      ill_nxt     = op_illegal;
`ifndef BARREL_SHIFT_EN
      state_nxt   = state;
      shift_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_shift && (shamt != '0)) begin
                  shift_start = 1'b1;
                  state_nxt   = ST_SHIFT;
               end else begin
                  load_result = 1'b1;
                  ov_nxt      = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (sh_done) begin
               load_result = 1'b1;
               res_nxt     = sh_result;
               ill_nxt     = 1'b0;
               ov_nxt      = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
`else
      if (accept) begin
         load_result = 1'b1;
         ov_nxt      = 1'b1;
      end
`endif
      // Flush wins over both a fresh accept and a completing shift.
      if (flush) begin
         ov_nxt      = 1'b0;
         load_result = 1'b0;
`ifndef BARREL_SHIFT_EN
         shift_start = 1'b0;
         state_nxt   = ST_IDLE;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b0;
         Illegal   <= 1'b0;
      end else begin
         out_valid <= ov_nxt;
         if (load_result) begin
            ALUResult <= res_nxt;
            Zero      <= (res_nxt == '0);
            Illegal   <= ill_nxt;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized traffic against a
// latency/queue-level reference model.
module tb_alu_exec_unit;
   import alu_exec_pkg::*;

   localparam int W = 32;
`ifdef BARREL_SHIFT_EN
   localparam bit ITER = 1'b0;
`else
   localparam bit ITER = 1'b1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   ALUOperation = 4'b0000;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [4:0]   shamt = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] ALUResult;
   logic         Zero;
   logic         Illegal;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ALUOperation (ALUOperation),
      .A            (A),
      .B            (B),
      .shamt        (shamt),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .ALUResult    (ALUResult),
      .Zero         (Zero),
      .Illegal      (Illegal)
   );

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [4:0] sh);
      logic [W-1:0] t;
      case (op)
         4'b0000: return a + b;
         4'b0001: return a & b;
         4'b0010: return a | b;
         4'b0011: return ~(a | b);
         4'b0100: return b << sh;
         4'b0101: return b >> sh;
         4'b0110: return {b[15:0], 16'h0000};
         4'b0111: return a - b;
         4'b1001: return a;
         4'b1010: begin
            t = a + b - 32'h1001_0000;
            return t >> 2;
         end
         default: return '0;
      endcase
   endfunction

   function automatic bit ref_illegal(input logic [3:0] op);
      return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                          4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010});
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [4:0] sh);
      if (ITER && (op == 4'b0100 || op == 4'b0101) && sh != 0) return int'(sh) + 1;
      return 1;
   endfunction

   bit           m_valid = 1'b0;
   logic [W-1:0] m_res   = '0;
   bit           m_zero  = 1'b0;
   bit           m_ill   = 1'b0;
   int           m_wait  = 0;
   logic [W-1:0] p_res   = '0;
   bit           p_ill   = 1'b0;
   bit           m_rdy;

   function automatic bit exp_ready();
      return (m_wait == 0) && (!m_valid || out_ready) && !flush;
   endfunction

   task automatic model_commit();
      m_res   = p_res;
      m_ill   = p_ill;
      m_zero  = (p_res == '0);
      m_valid = 1'b1;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid = 1'b0;
         m_res   = '0;
         m_zero  = 1'b0;
         m_ill   = 1'b0;
         m_wait  = 0;
      end else begin
         m_rdy = exp_ready();
         if (flush) begin
            m_valid = 1'b0;
            m_wait  = 0;
         end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_wait > 0) begin
               m_wait--;
               if (m_wait == 0) model_commit();
            end else if (in_valid && m_rdy) begin
               p_res  = ref_result(ALUOperation, A, B, shamt);
               p_ill  = ref_illegal(ALUOperation);
               m_wait = ref_latency(ALUOperation, shamt) - 1;
               if (m_wait == 0) model_commit();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, exp_ready());
         chk("out_valid", out_valid, m_valid);
         chk("ALUResult", ALUResult, m_res);
         chk("Zero", Zero, m_zero);
         chk("Illegal", Illegal, m_ill);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh);
      int n;
      n = 0;
      ALUOperation = op;
      A = a;
      B = b;
      shamt = sh;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 100) begin
         step();
         n++;
      end
      chk("issue_accept_wait", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      shamt = 5'($urandom);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      #2 reset = 1'b0;
      chk_en = 1'b1;
      step();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", ALUResult, '0);
      chk("rst_zero", Zero, 1'b0);
      chk("rst_illegal", Illegal, 1'b0);
      step();
      reset = 1'b1;
      step();

      chk("ref_add", ref_result(OP_ADD, 5, 3, 0), 32'd8);
      chk("ref_memmap", ref_result(OP_MEMMAP, 32'h1001_0000, 8, 0), 32'd2);
      chk("ref_sll31", ref_result(OP_SLL, 0, 1, 31), 32'h8000_0000);
      chk("ref_srl4", ref_result(OP_SRL, 0, 32'h8000_0000, 4), 32'h0800_0000);
      chk("ref_lui", ref_result(OP_LUI, 0, 32'hABCD_1234, 0), 32'h1234_0000);
      chk("ref_illegal", ref_illegal(4'b1000), 1'b1);

      out_ready = 1'b1;
      issue(OP_ADD, 5, 3, 0);
      chk("add_valid", out_valid, 1'b1);
      chk("add_result", ALUResult, 32'd8);
      chk("add_zero", Zero, 1'b0);

      issue(OP_SUB, 32'h1234, 32'h1234, 0);
      chk("sub_result", ALUResult, 32'd0);
      chk("sub_zero", Zero, 1'b1);
      issue(OP_NOR, 0, 0, 0);
      chk("nor_result", ALUResult, 32'hFFFF_FFFF);

      issue(OP_SLL, 32'h5555_5555, 1, 31);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         chk("sll_busy_ready", in_ready, 1'b0);
         step();
         cyc++;
      end
      chk("sll_latency", cyc, ITER ? 32 : 1);
      chk("sll_result", ALUResult, 32'h8000_0000);

      issue(OP_MEMMAP, 32'h1001_0000, 8, 0);
      chk("memmap_result", ALUResult, 32'd2);
      issue(4'b1011, 32'h77, 32'h88, 0);
      chk("illegal_flag", Illegal, 1'b1);
      chk("illegal_result", ALUResult, 32'd0);
      issue(OP_ADD, 7, 9, 0);
      chk("illegal_clear", Illegal, 1'b0);
      chk("add2_result", ALUResult, 32'd16);

      issue(OP_ADD, 10, 20, 0);
      out_ready = 1'b0;
      repeat (5) begin
         step();
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_result", ALUResult, 32'd30);
         chk("hold_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      ALUOperation = OP_OR;
      A = 32'hF0;
      B = 32'h0F;
      in_valid = 1'b1;
      #1;
      chk("b2b_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_result", ALUResult, 32'hFF);

      issue(OP_SLL, 0, 3, 10);
      repeat (3) step();
      flush = 1'b1;
      #1;
      chk("flush_ready", in_ready, 1'b0);
      step();
      flush = 1'b0;
      #1;
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_idle", in_ready, 1'b1);
      repeat (12) begin
         step();
         chk("flush_no_result", out_valid, 1'b0);
      end

      issue(OP_ADD, 1, 1, 0);
      issue(OP_SLL, 0, 5, 20);
      repeat (5) step();
      #2 reset = 1'b0;
      #1;
      chk("rstmid_valid", out_valid, 1'b0);
      chk("rstmid_result", ALUResult, 32'd0);
      chk("rstmid_zero", Zero, 1'b0);
      chk("rstmid_illegal", Illegal, 1'b0);
      step();
      reset = 1'b1;
      step();

      for (int i = 0; i < 2500; i++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         out_ready    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 39) == 0);
         ALUOperation = 4'($urandom_range(0, 15));
         A            = $urandom;
         B            = ($urandom_range(0, 7) == 0) ? A : $urandom;
         shamt        = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 3));
         step();
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (40) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage consumer of the 4-bit ALUOperation code produced by the ALU control decoder in the pipelined MIPS. It accepts an operation and its operands over a valid/ready handshake and computes the result. It registers the result toward the EX/MEM boundary. Shifts are iterative by default, one bit per cycle, so the block must back-pressure the pipeline through its state machine.

Parameters:
DATA_WIDTH, 32, operand/result width.
MEM_BASE, 32'h1001_0000, data-segment base subtracted for memory-map address ops.
SHAMT_WIDTH, 5, shift-amount width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous squash of in-flight and held op
in_valid  input  1  operation presented
in_ready  output  1  block can accept this cycle
ALUOperation  input  4  operation code from ALU control
A  input  DATA_WIDTH  rs operand
B  input  DATA_WIDTH  rt/immediate operand
shamt  input  SHAMT_WIDTH  shift amount
out_valid  output  1  ALUResult valid
out_ready  input  1  downstream accepts result
ALUResult  output  DATA_WIDTH  registered result
Zero  output  1  ALUResult == 0
Illegal  output  1  unsupported code was executed

Behaviour:
- Reset (async, reset==0): state=IDLE; out_valid=0, ALUResult=0, Zero=0, Illegal=0; shift counter=0.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready. Operands are captured at accept; later input changes are ignored.
- Operation codes:
  - 0000 ADD: A+B.
  - 0001 AND: A&B.
  - 0010 OR: A|B.
  - 0011 NOR: ~(A|B).
  - 0100 SLL: B<<shamt.
  - 0101 SRL: B>>shamt, logical.
  - 0110 LUI: {B[15:0],16'h0}.
  - 0111 SUB: A-B.
  - 1001 JUMP/JR: result = A (jump-register target passthrough).
  - 1010 MEMMAP: (A+B-MEM_BASE)>>2, word index.
  - All other codes (1000, 1011-1111): result=0, Illegal=1.
- All arithmetic is modulo 2^DATA_WIDTH; no overflow trap.
- Latency for non-shift ops: out_valid rises the cycle after accept, so the result arrives 1 cycle after accept.
- Shift path:
  - shamt==0: completes in 1 cycle, like a non-shift op.
  - Otherwise: enter SHIFT with counter=shamt and working reg=B.
  - Each cycle: shift by 1 and decrement the counter.
  - When the counter reaches 0: load ALUResult, assert out_valid, return to IDLE.
  - Total latency: shamt+1 cycles after accept (shamt=31 gives 32 cycles).
- Output hold: ALUResult, Zero and Illegal are stable while out_valid && !out_ready.
- Back-to-back: in IDLE, an out_valid&&out_ready transfer and a new accept may occur in the same cycle, giving full throughput for non-shift ops.
- Zero and Illegal are registered with ALUResult. Illegal clears on the next completed legal op.
- flush:
  - Clears out_valid and forces IDLE next cycle, aborting any SHIFT.
  - Flush has priority over accept and over shift completion.
  - ALUResult/Zero/Illegal keep their values but are not valid.
- Reset mid-shift: immediate return to reset values; no result is produced.

Optional Feature:
BARREL_SHIFT_EN.
- Defined: SLL/SRL are computed combinationally at accept with 1-cycle latency; the SHIFT state is not instantiated and in_ready ignores state.
- Undefined: iterative shifter as described above.
- Results must be bit-identical in both builds.

Decomposition:
- Package alu_exec_pkg holds:
  - ALUOperation code localparams (OP_ADD, OP_AND, OP_OR, OP_NOR, OP_SLL, OP_SRL, OP_LUI, OP_SUB, OP_JMP, OP_MEMMAP), shared with the ALU control decoder.
  - State encoding (ST_IDLE, ST_SHIFT).
  - Default MEM_BASE.
- One sub-module: alu_serial_shifter, covering the counter, working register, direction and done pulse. It is bypassed under BARREL_SHIFT_EN.

Test Plan:
- After reset, drive A=5, B=3, op 0000 with out_ready=1: one cycle later out_valid=1, ALUResult=8, Zero=0.
- Drive op 0111 with A=B=32'h1234: ALUResult=0, Zero=1. Then op 0011 with A=B=0: ALUResult=32'hFFFF_FFFF.
- Drive op 0100, B=1, shamt=31: in_ready=0 for 31 cycles; out_valid on cycle 32 after accept with ALUResult=32'h8000_0000. With BARREL_SHIFT_EN, latency is 1.
- Drive op 1010, A=32'h1001_0000, B=8: ALUResult=2. Drive op 1011: Illegal=1, ALUResult=0. A following ADD clears Illegal.
- Hold out_ready=0 with out_valid=1 for 5 cycles: ALUResult is stable and in_ready=0. Raise out_ready together with a new in_valid: transfer and accept in the same cycle.
- Assert flush during SHIFT (shamt=10, cycle 4): next cycle state=IDLE, out_valid=0. Assert reset mid-shift: all outputs return to 0 asynchronously.
